// File: rtl/matmul_pkg.sv
// matmul_pkg: FSM state type and job-size helper shared by matmul_seq.
package matmul_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, START, WAIT, DRAIN_RD, DRAIN_OUT} state_t;
  function automatic int job_words(input int v);
    return v * v;
  endfunction
endpackage

// File: rtl/matmul_seq_if.sv
// matmul_seq_if: job command, operand stream and result stream handshakes.
interface matmul_seq_if #(parameter int DATA_WIDTH = 32);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  modport master (output cmd_valid, input cmd_ready, output in_data, output in_valid, input in_ready,
                  input out_data, input out_valid, output out_ready);
  modport slave  (input cmd_valid, output cmd_ready, input in_data, input in_valid, output in_ready,
                  output out_data, output out_valid, input out_ready);
endinterface

// File: rtl/matmul_seq.sv
// matmul_seq: sequences X/Y loads into BRAM, starts the engine and drains Z as a stream.
// Optional engine cycle counter enabled by defining MATMUL_SEQ_PERF_EN.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int VECTOR_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  matmul_seq_if.slave           s,
  output logic                  busy,
  output logic                  mm_start,
  input  logic                  mm_done,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [ADDR_WIDTH-1:0] x_wr_addr,
  output logic                  x_wr_en,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic [ADDR_WIDTH-1:0] y_wr_addr,
  output logic                  y_wr_en,
  output logic [ADDR_WIDTH-1:0] z_rd_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic [31:0]           perf_cycles
);
  localparam int N = job_words(VECTOR_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);
  if (N > 2 ** ADDR_WIDTH) begin : g_size_chk
    $error("matmul_seq: VECTOR_SIZE*VECTOR_SIZE exceeds BRAM depth");
  end
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  last, load_x, load_y, drain;
  assign last   = cnt_q == LAST;
  assign load_x = state_q == LOAD_X;
  assign load_y = state_q == LOAD_Y;
  assign drain  = state_q == DRAIN_RD || state_q == DRAIN_OUT;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (s.cmd_valid) begin
        state_d = LOAD_X;
        cnt_d   = '0;
      end
      LOAD_X: if (s.in_valid) begin
        state_d = last ? LOAD_Y : LOAD_X;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
      end
      LOAD_Y: if (s.in_valid) begin
        state_d = last ? START : LOAD_Y;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
      end
      START: state_d = WAIT;
      WAIT: if (mm_done) begin
        state_d = DRAIN_RD;
        cnt_d   = '0;
      end
      DRAIN_RD: state_d = DRAIN_OUT;
      DRAIN_OUT: if (s.out_ready) begin
        state_d = last ? IDLE : DRAIN_RD;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  assign s.cmd_ready = state_q == IDLE;
  assign s.in_ready  = load_x | load_y;
  assign s.out_valid = state_q == DRAIN_OUT;
  // z_rd_addr is held through DRAIN_OUT, so out_data stays stable under backpressure
  assign s.out_data  = s.out_valid ? z_dout : '0;
  assign busy        = state_q != IDLE;
  assign mm_start    = state_q == START;
  assign x_wr_en     = load_x & s.in_valid;
  assign x_wr_addr   = load_x ? cnt_q : '0;
  assign x_din       = load_x ? s.in_data : '0;
  assign y_wr_en     = load_y & s.in_valid;
  assign y_wr_addr   = load_y ? cnt_q : '0;
  assign y_din       = load_y ? s.in_data : '0;
  assign z_rd_addr   = drain ? cnt_q : '0;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] pc_q, pc_d, perf_q, perf_d, pc_inc;
  assign pc_inc = &pc_q ? pc_q : pc_q + 32'd1;
  always_comb begin
    pc_d   = mm_start ? '0 : (state_q == WAIT ? pc_inc : pc_q);
    perf_d = (state_q == WAIT && mm_done) ? pc_inc : perf_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= '0;
      perf_q <= '0;
    end else begin
      pc_q   <= pc_d;
      perf_q <= perf_d;
    end
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif
endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32: word width of the matrix elements.
REQ-002 Parameter ADDR_WIDTH SHALL default to 6: BRAM address width.
REQ-003 Parameter VECTOR_SIZE SHALL default to 8: matrix dimension; job size N = VECTOR_SIZE*VECTOR_SIZE words per matrix.
REQ-004 The block SHALL have exactly one clock; reset is synchronous and active-high. Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid / cmd_ready  in / out  1 / 1  job request handshake.
- in_data / in_valid / in_ready  in / in / out  DATA_WIDTH / 1 / 1  operand stream, X then Y, row-major.
- out_data / out_valid / out_ready  out / out / in  DATA_WIDTH / 1 / 1  result stream Z, row-major.
- busy  out  1  high in any non-IDLE state.
- mm_start / mm_done  out / in  1 / 1  engine start pulse; engine completion.
- x_din, x_wr_addr, x_wr_en  out  DATA_WIDTH, ADDR_WIDTH, 1  X BRAM write port.
- y_din, y_wr_addr, y_wr_en  out  DATA_WIDTH, ADDR_WIDTH, 1  Y BRAM write port.
- z_rd_addr / z_dout  out / in  ADDR_WIDTH / DATA_WIDTH  Z BRAM read port, 1-cycle read latency.
- perf_cycles  out  32  engine cycle count of the last job.

Function
REQ-005 FSM states SHALL be IDLE, LOAD_X, LOAD_Y, START, WAIT, DRAIN_RD, DRAIN_OUT.
REQ-006 IDLE: cmd_ready=1; cmd_valid&cmd_ready SHALL go to LOAD_X with word counter cnt=0.
REQ-007 LOAD_X/LOAD_Y: in_ready=1; each in_valid&in_ready beat SHALL write in_data to x (resp. y) at address cnt in the same cycle (wr_en combinational from the handshake) and increment cnt.
REQ-008 The beat with cnt=N-1 SHALL clear cnt and advance LOAD_X->LOAD_Y or LOAD_Y->START; no beat is lost or duplicated at the boundary.
REQ-009 START: mm_start SHALL be high for exactly one cycle, then WAIT.
REQ-010 WAIT: mm_done SHALL be sampled from the first WAIT cycle; mm_done=1 SHALL go to DRAIN_RD with cnt=0.
REQ-011 DRAIN_RD: z_rd_addr=cnt for one cycle, then DRAIN_OUT. DRAIN_OUT: z_rd_addr held at cnt, out_valid=1, out_data=z_dout; out_ready=1 SHALL increment cnt and return to DRAIN_RD, or to IDLE after cnt=N-1. Throughput: one word per 2 cycles, unlimited backpressure.
REQ-012 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-013 cmd_valid outside IDLE SHALL be ignored (cmd_ready=0); in_valid outside LOAD_X/LOAD_Y SHALL be ignored (in_ready=0).
REQ-014 BRAM write enables SHALL be 0 outside LOAD_X/LOAD_Y; z_rd_addr SHALL be 0 outside drain states.
REQ-015 cnt SHALL be ADDR_WIDTH bits; N SHALL not exceed 2**ADDR_WIDTH (elaboration-time check).

Reset
REQ-016 On reset, the FSM SHALL enter IDLE and cnt=0. All outputs SHALL be 0 except cmd_ready=1; perf_cycles SHALL be 0.
REQ-017 Reset mid-job SHALL abort the job in one cycle; BRAM contents are not cleared; no partial out beat follows.

Configuration
REQ-018 With MATMUL_SEQ_PERF_EN defined, a 32-bit counter SHALL clear on mm_start, increment each WAIT cycle, saturate at 2**32-1, and latch into perf_cycles on WAIT exit. Without it, perf_cycles SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-019 Package matmul_pkg SHALL hold the FSM state enum typedef and a localparam function for N; matmul_seq imports it.
REQ-020 No sub-module; the FSM, counter and optional perf counter are flat in matmul_seq.

Verification
REQ-021 Identity X, Y=1..64, engine model returns X*Y -> out stream 1..64 in order; busy drops the cycle after the last beat.
REQ-022 in_valid toggled 1/0 each cycle across the X->Y boundary -> y_wr_addr 0 receives the 65th accepted word; exactly 64 writes per BRAM.
REQ-023 out_ready held 0 for 10 cycles at word 5 -> out_data is constant; word 6 follows only after release.
REQ-024 Reset asserted in WAIT -> next cycle IDLE, cmd_ready=1, mm_done then high is ignored, no out_valid.
REQ-025 cmd_valid pulsed during LOAD_Y -> no effect; second job after IDLE completes normally.
REQ-026 With MATMUL_SEQ_PERF_EN, engine model raising mm_done 100 cycles after mm_start -> perf_cycles=100; without the macro -> 0.
